// File: rtl/receiver_sample_fifo_pkg.sv
// Shared constants and head-state encoding for the receiver sample FIFO.
package rx_pkg;

  localparam int RX_DATA_W = 16;
  localparam int RX_ADDR_W = 16;

  typedef enum logic {
    RX_HEAD_EMPTY  = 1'b0,
    RX_HEAD_LOADED = 1'b1
  } rx_head_e;

endpackage

// File: rtl/receiver_sample_fifo_ram.sv
// Simple dual-port sample store with a registered, write-first read port.
module rx_sample_ram
  import rx_pkg::*;
#(
  parameter int DATA_W = RX_DATA_W,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // A read of the slot being written returns the new sample, so a head loaded
  // from a freshly written slot is never stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/receiver_sample_fifo.sv
// First-word-fall-through buffer for the receiver sample stream.
// Optional address continuity check enabled by defining RX_ADDR_CHECK_EN.
module receiver_sample_fifo
  import rx_pkg::*;
#(
  parameter int DATA_W     = RX_DATA_W,
  parameter int ADDR_W     = RX_ADDR_W,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [ADDR_W-1:0]     write_addr,
  input  logic                  write_en,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  clear_ovf,
  output logic                  addr_err
);

  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [PTR_W-1:0] ONE      = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  rx_head_e         head_q, head_d;
  logic             ovf_q, ovf_d;

  logic [PTR_W-1:0] fill;
  logic             full, pop, push, drop, ram_re;

  assign fill = wr_ptr_q - rd_ptr_q;
  assign full = (fill == FULL_LVL);
  assign pop  = (head_q == RX_HEAD_LOADED) && out_ready;
  assign push = write_en && (!full || pop);
  assign drop = write_en && full && !pop;

  // Reload the head only when a real sample will sit at the new read slot.
  assign ram_re = (push && (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_d[DEPTH_LOG2-1:0]))
                || (pop && (fill > ONE));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + ONE;
    if (clear_ovf) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
    case (head_q)
      RX_HEAD_EMPTY:  if (fill != '0) head_d = RX_HEAD_LOADED;
      RX_HEAD_LOADED: if (pop && (fill == ONE) && !push) head_d = RX_HEAD_EMPTY;
      default:        head_d = RX_HEAD_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= RX_HEAD_EMPTY;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  rx_sample_ram #(
    .DATA_W (DATA_W),
    .AW     (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (push),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i (write_data),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_d[DEPTH_LOG2-1:0]),
    .rdata_o (out_data)
  );

  assign out_valid = (head_q == RX_HEAD_LOADED);
  assign level     = fill;
  assign overflow  = ovf_q;

`ifdef RX_ADDR_CHECK_EN
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic              armed_q, armed_d;
  logic              addr_err_q, addr_err_d;

  // Every strobe, dropped or not, advances the expected index.
  always_comb begin
    exp_addr_d = exp_addr_q;
    armed_d    = armed_q;
    addr_err_d = addr_err_q;
    if (clear_ovf) addr_err_d = 1'b0;
    if (write_en) begin
      if (armed_q && (write_addr != exp_addr_q)) addr_err_d = 1'b1;
      exp_addr_d = write_addr + ADDR_W'(1);
      armed_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_addr_q <= '0;
      armed_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      exp_addr_q <= exp_addr_d;
      armed_q    <= armed_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_err = addr_err_q;
`else
  logic unused_addr;
  assign unused_addr = ^write_addr;
  assign addr_err    = 1'b0;
`endif

endmodule
